// File: rtl/axi_lite_sram_if.sv
// AXI4-Lite bus bundle between a master and the axi_lite_sram endpoint.
// Latency: none, wires only.
// Backpressure: carried by the per-channel VALID/READY pairs.
interface axi_lite_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave over a word-addressed SRAM; one transaction at a time, round-robin read/write arbitration.
// Latency: write visible after the W handshake edge, BVALID next cycle; RVALID/RDATA one cycle after AR.
// Backpressure: B/R payloads held until BREADY/RREADY; no new AR/AW accepted while a response is pending.
module axi_lite_sram #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 16384
) (
  input logic             ACLK,
  input logic             ARESETn,
  axi_lite_sram_if.slave  s_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    W_WAIT = 2'd1,
    B_RESP = 2'd2,
    R_RESP = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Backdoor-visible storage; deliberately never reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                state_q;
  logic                  pref_wr_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  idle;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  w_fire;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_in_range;
  logic [IDX_W-1:0]      wr_idx;
  logic                  rd_in_range;
  logic [IDX_W-1:0]      rd_idx;
  logic                  unused_addr_bits;

  // Arbitration only happens in IDLE; pref_wr breaks ties when both sides request.
  assign idle     = (state_q == IDLE);
  assign grant_wr = idle & s_axi.AWVALID & (~s_axi.ARVALID | pref_wr_q);
  assign grant_rd = idle & s_axi.ARVALID & (~s_axi.AWVALID | ~pref_wr_q);

  assign s_axi.AWREADY = grant_wr;
  assign s_axi.ARREADY = grant_rd;
  assign s_axi.WREADY  = grant_wr | (state_q == W_WAIT);

  assign s_axi.BVALID = bvalid_q;
  assign s_axi.BRESP  = bresp_q;
  assign s_axi.RVALID = rvalid_q;
  assign s_axi.RRESP  = rresp_q;
  assign s_axi.RDATA  = rdata_q;

  // W may land together with AW (use the live address) or later (use the latched one).
  assign w_fire      = s_axi.WVALID & s_axi.WREADY;
  assign wr_addr     = idle ? s_axi.AWADDR : awaddr_q;
  assign wr_in_range = (wr_addr[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign rd_in_range = (s_axi.ARADDR[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign rd_idx      = s_axi.ARADDR[IDX_W+1:2];

  // Byte offsets are ignored: the array is word addressed.
  assign unused_addr_bits = ^{wr_addr[1:0], s_axi.ARADDR[1:0]};

  // Byte-lane write into the array; out-of-range writes and writes under reset are dropped.
  always_ff @(posedge ACLK) begin
    if (ARESETn && w_fire && wr_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi.WSTRB[i]) begin
          mem[wr_idx][8*i +: 8] <= s_axi.WDATA[8*i +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered response channels and the round-robin pointer.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      pref_wr_q <= 1'b1;
      awaddr_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            pref_wr_q <= 1'b0;
            if (s_axi.WVALID) begin
              bvalid_q <= 1'b1;
              bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
              state_q  <= B_RESP;
            end else begin
              awaddr_q <= s_axi.AWADDR;
              state_q  <= W_WAIT;
            end
          end else if (grant_rd) begin
            pref_wr_q <= 1'b1;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_in_range ? mem[rd_idx] : '0;
            rresp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            state_q   <= R_RESP;
          end
        end
        W_WAIT: begin
          if (s_axi.WVALID) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            state_q  <= B_RESP;
          end
        end
        B_RESP: begin
          if (s_axi.BREADY) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        R_RESP: begin
          if (s_axi.RREADY) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench for axi_lite_sram with a queue scoreboard checked by a separate monitor.
// Latency: checks BVALID/RVALID one cycle after the address handshake.
// Backpressure: exercises held RREADY/BREADY and simultaneous AW/AR contention.
module tb_axi_lite_sram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  axi_lite_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_sram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(16384)) dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .s_axi   (bus)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // Monitor: pops the scoreboard whenever a response handshake is seen.
  always @(negedge clk) begin
    logic [1:0]  eb;
    logic [33:0] er;
    if (rst_n) begin
      if (bus.BVALID && bus.BREADY) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got BRESP %h with nothing expected", bus.BRESP);
        end else begin
          eb = exp_b.pop_front();
          chk("bresp", {30'd0, bus.BRESP}, {30'd0, eb});
        end
      end
      if (bus.RVALID && bus.RREADY) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got RDATA %h with nothing expected", bus.RDATA);
        end else begin
          er = exp_r.pop_front();
          chk("rdata", bus.RDATA, er[33:2]);
          chk("rresp", {30'd0, bus.RRESP}, {30'd0, er[1:0]});
        end
      end
    end
  end

  // Entered just after a rising edge; returns just after a rising edge.
  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] resp);
    int n;
    exp_b.push_back(resp);
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.AWREADY && bus.WREADY) && n < 50);
    if (!(bus.AWREADY && bus.WREADY)) timeout("wr_accept");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk("bvalid_next_cycle", {31'd0, bus.BVALID}, 32'd1);
    n = 0;
    while (bus.BVALID && n < 50) begin @(posedge clk); #1; n++; end
    if (bus.BVALID) timeout("wr_bresp");
  endtask

  task automatic axi_rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    int n;
    exp_r.push_back({d, resp});
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ARREADY && n < 50);
    if (!bus.ARREADY) timeout("rd_accept");
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    chk("rvalid_next_cycle", {31'd0, bus.RVALID}, 32'd1);
    n = 0;
    while (bus.RVALID && n < 50) begin @(posedge clk); #1; n++; end
    if (bus.RVALID) timeout("rd_resp");
  endtask

  // Read with RREADY held low for 5 cycles; payload must stay put.
  task automatic axi_rd_bp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    int n;
    exp_r.push_back({d, resp});
    bus.RREADY = 1'b0;
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ARREADY && n < 50);
    if (!bus.ARREADY) timeout("rd_bp_accept");
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rvalid", {31'd0, bus.RVALID}, 32'd1);
      chk("bp_rdata", bus.RDATA, d);
      chk("bp_rresp", {30'd0, bus.RRESP}, {30'd0, resp});
      chk("bp_no_arready", {31'd0, bus.ARREADY}, 32'd0);
    end
    @(posedge clk); #1;
    bus.RREADY = 1'b1;
    n = 0;
    while (bus.RVALID && n < 50) begin @(posedge clk); #1; n++; end
    if (bus.RVALID) timeout("rd_bp_resp");
  endtask

  initial begin
    int n;
    int grants;
    logic gseq [4];
    logic [3:0] exp_seq;

    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    for (int i = 0; i < 4; i++) gseq[i] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bvalid", {31'd0, bus.BVALID}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.RVALID}, 32'd0);
    chk("rst_bresp", {30'd0, bus.BRESP}, 32'd0);
    chk("rst_rresp", {30'd0, bus.RRESP}, 32'd0);
    chk("rst_rdata", bus.RDATA, 32'd0);
    chk("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    chk("rst_arready", {31'd0, bus.ARREADY}, 32'd0);
    chk("rst_wready", {31'd0, bus.WREADY}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read at word 0x100
    axi_wr(32'h400, 32'hDEADBEEF, 4'hF, 2'b00);
    chk("mem_0x100", dut.mem[256], 32'hDEADBEEF);
    axi_rd(32'h400, 32'hDEADBEEF, 2'b00);
    axi_wr(32'h0, 32'h0BADF00D, 4'hF, 2'b00);

    // Byte strobes
    axi_wr(32'h4, 32'h11223344, 4'hF, 2'b00);
    axi_wr(32'h4, 32'hAABBCCDD, 4'h5, 2'b00);
    chk("mem_strobe", dut.mem[1], 32'h11BB33DD);
    axi_rd(32'h4, 32'h11BB33DD, 2'b00);

    // Split write with a read waiting behind it
    axi_wr(32'h8, 32'h0, 4'hF, 2'b00);
    exp_b.push_back(2'b00);
    exp_r.push_back({32'h5A5A5A5A, 2'b00});
    bus.AWADDR = 32'h8; bus.AWVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.AWREADY && n < 50);
    if (!bus.AWREADY) timeout("split_aw");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.ARADDR = 32'h8; bus.ARVALID = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("split_wready", {31'd0, bus.WREADY}, 32'd1);
      chk("split_bvalid", {31'd0, bus.BVALID}, 32'd0);
      chk("split_arready_blocked", {31'd0, bus.ARREADY}, 32'd0);
      chk("split_awready", {31'd0, bus.AWREADY}, 32'd0);
    end
    @(posedge clk); #1;
    bus.WDATA = 32'h5A5A5A5A; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(negedge clk);
    chk("split_wready_last", {31'd0, bus.WREADY}, 32'd1);
    chk("split_mem_before", dut.mem[2], 32'h0);
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
    chk("split_bvalid_after", {31'd0, bus.BVALID}, 32'd1);
    chk("split_mem_after", dut.mem[2], 32'h5A5A5A5A);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ARREADY && n < 50);
    if (!bus.ARREADY) timeout("split_ar");
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    n = 0;
    while (bus.RVALID && n < 50) begin @(posedge clk); #1; n++; end
    if (bus.RVALID) timeout("split_r");

    // Out-of-range accesses and read backpressure
    axi_wr(32'h10000, 32'hFFFFFFFF, 4'hF, 2'b10);
    chk("oor_no_alias", dut.mem[0], 32'h0BADF00D);
    axi_rd_bp(32'h400, 32'hDEADBEEF, 2'b00);
    axi_rd_bp(32'h10000, 32'h0, 2'b10);

    // Contention from reset release: grants must alternate starting with write
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_b.push_back(2'b00); exp_b.push_back(2'b00);
    exp_r.push_back({32'h600DCAFE, 2'b00}); exp_r.push_back({32'h600DCAFE, 2'b00});
    bus.AWADDR = 32'h20; bus.WDATA = 32'h600DCAFE; bus.WSTRB = 4'hF;
    bus.ARADDR = 32'h20;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    rst_n = 1'b1;
    grants = 0; n = 0;
    while (grants < 4 && n < 40) begin
      @(negedge clk);
      n++;
      chk("both_ready", {31'd0, bus.AWREADY & bus.ARREADY}, 32'd0);
      if (bus.AWREADY) begin gseq[grants] = 1'b1; grants++; end
      else if (bus.ARREADY) begin gseq[grants] = 1'b0; grants++; end
    end
    if (grants < 4) timeout("contention_grants");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    exp_seq = 4'b0101;
    for (int i = 0; i < 4; i++) chk("grant_order", {31'd0, gseq[i]}, {31'd0, exp_seq[i]});
    n = 0;
    while ((bus.RVALID || bus.BVALID) && n < 50) begin @(posedge clk); #1; n++; end
    if (bus.RVALID || bus.BVALID) timeout("contention_drain");

    // Reset while in B_RESP
    bus.BREADY = 1'b0;
    bus.AWADDR = 32'h30; bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.AWREADY && bus.WREADY) && n < 50);
    if (!(bus.AWREADY && bus.WREADY)) timeout("rstmid_accept");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk("rstmid_bvalid_before", {31'd0, bus.BVALID}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_bvalid_async", {31'd0, bus.BVALID}, 32'd0);
    chk("rstmid_mem_kept", dut.mem[12], 32'hCAFEF00D);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    axi_rd(32'h30, 32'hCAFEF00D, 2'b00);

    // Scoreboard must be drained
    n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 20) begin @(posedge clk); #1; n++; end
    chk("sb_b_left", exp_b.size(), 32'd0);
    chk("sb_r_left", exp_r.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
